// File: rtl/fu_wb_arb.sv
// fu_wb_arb: writeback arbiter for the functional-unit cluster.
// Each of NUM_CH execution channels feeds a DEPTH-entry FIFO; one record per
// cycle is moved into a registered ready/valid writeback port towards the
// ROB/PRF. Issuing an exception record raises a sticky stall that
// back-pressures every channel until reset or flush.
// Optional macro FU_WB_ARB_AGE_EN: adds rob_head_i and replaces round-robin
// arbitration with oldest-first selection relative to the ROB head.
// Note: rstn is an active-high synchronous reset (asserted = 1).
module fu_wb_arb #(
    parameter int NUM_CH               = 3,
    parameter int DEPTH                = 2,
    parameter int XLEN                 = 64,
    parameter int ROB_INDEX_WIDTH      = 4,
    parameter int PHY_REG_ADDR_WIDTH   = 6,
    parameter int EXCEPTION_CODE_WIDTH = 4
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic                                   flush,
    input  logic [NUM_CH-1:0]                      ch_valid_i,
    output logic [NUM_CH-1:0]                      ch_ready_o,
    input  logic [NUM_CH*ROB_INDEX_WIDTH-1:0]      ch_rob_index_i,
    input  logic [NUM_CH-1:0]                      ch_rd_we_i,
    input  logic [NUM_CH*PHY_REG_ADDR_WIDTH-1:0]   ch_rd_addr_i,
    input  logic [NUM_CH*XLEN-1:0]                 ch_data_i,
    input  logic [NUM_CH-1:0]                      ch_exc_valid_i,
    input  logic [NUM_CH*EXCEPTION_CODE_WIDTH-1:0] ch_ecause_i,
    output logic                                   wb_valid_o,
    input  logic                                   wb_ready_i,
    output logic [ROB_INDEX_WIDTH-1:0]             wb_rob_index_o,
    output logic                                   wb_rd_we_o,
    output logic [PHY_REG_ADDR_WIDTH-1:0]          wb_rd_addr_o,
    output logic [XLEN-1:0]                        wb_data_o,
    output logic                                   wb_exc_valid_o,
    output logic [EXCEPTION_CODE_WIDTH-1:0]        wb_ecause_o,
    output logic [$clog2(NUM_CH)-1:0]              wb_ch_o,
    output logic                                   exc_stall_o
`ifdef FU_WB_ARB_AGE_EN
    ,
    input  logic [ROB_INDEX_WIDTH-1:0]             rob_head_i
`endif
);

    localparam int RW   = ROB_INDEX_WIDTH;
    localparam int PW   = PHY_REG_ADDR_WIDTH;
    localparam int EW   = EXCEPTION_CODE_WIDTH;
    localparam int CW   = $clog2(NUM_CH);
    localparam int SW   = CW + 1;
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    typedef struct packed {
        logic [RW-1:0]   rob;
        logic            we;
        logic [PW-1:0]   rd;
        logic [XLEN-1:0] data;
        logic            exc;
        logic [EW-1:0]   ecause;
    } rec_t;

    rec_t            mem        [NUM_CH][DEPTH];
    logic [AW-1:0]   wr_ptr     [NUM_CH];
    logic [AW-1:0]   rd_ptr     [NUM_CH];
    logic [CNTW-1:0] count      [NUM_CH];
    logic [CNTW-1:0] count_next [NUM_CH];
    rec_t            in_rec     [NUM_CH];
    rec_t            head_rec   [NUM_CH];

    logic [NUM_CH-1:0] enq;
    logic [NUM_CH-1:0] deq;
    logic [NUM_CH-1:0] nonempty;
    logic [NUM_CH-1:0] ready_next;
    logic [CW-1:0]     rr_ptr;
    logic [CW-1:0]     rr_next;
    logic [CW-1:0]     grant_ch;
    logic              grant_found;
    logic              take;
    logic              load;
    logic              exc_pending;
    logic              stall_next;
    rec_t              sel_rec;
`ifdef FU_WB_ARB_AGE_EN
    logic [RW-1:0]     age;
    logic [RW-1:0]     best_age;
`else
    logic [SW-1:0]     arb_raw;
    logic [SW-1:0]     arb_sum;
    logic [CW-1:0]     arb_idx;
`endif

    // Unpack channel inputs and expose FIFO head/occupancy per channel.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            in_rec[c].rob    = ch_rob_index_i[c*RW +: RW];
            in_rec[c].we     = ch_rd_we_i[c];
            in_rec[c].rd     = ch_rd_addr_i[c*PW +: PW];
            in_rec[c].data   = ch_data_i[c*XLEN +: XLEN];
            in_rec[c].exc    = ch_exc_valid_i[c];
            in_rec[c].ecause = ch_ecause_i[c*EW +: EW];
            head_rec[c]      = mem[c][rd_ptr[c]];
            nonempty[c]      = (count[c] != {CNTW{1'b0}});
            enq[c]           = ch_valid_i[c] & ch_ready_o[c];
        end
    end

`ifdef FU_WB_ARB_AGE_EN
    // Oldest-first selection: smallest distance from the ROB head, ties to lowest channel.
    always_comb begin
        grant_found = 1'b0;
        grant_ch    = {CW{1'b0}};
        best_age    = {RW{1'b0}};
        age         = {RW{1'b0}};
        take        = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            age         = head_rec[i].rob - rob_head_i;
            take        = nonempty[i] & (~grant_found | (age < best_age));
            grant_ch    = take ? CW'(i) : grant_ch;
            best_age    = take ? age : best_age;
            grant_found = grant_found | take;
        end
    end
`else
    // Round-robin selection: first non-empty channel scanning upward from rr_ptr.
    always_comb begin
        grant_found = 1'b0;
        grant_ch    = {CW{1'b0}};
        arb_raw     = {SW{1'b0}};
        arb_sum     = {SW{1'b0}};
        arb_idx     = {CW{1'b0}};
        take        = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            arb_raw     = {1'b0, rr_ptr} + SW'(i);
            arb_sum     = (arb_raw >= SW'(NUM_CH)) ? (arb_raw - SW'(NUM_CH)) : arb_raw;
            arb_idx     = arb_sum[CW-1:0];
            take        = ~grant_found & nonempty[arb_idx];
            grant_ch    = take ? arb_idx : grant_ch;
            grant_found = grant_found | take;
        end
    end
`endif

    // Output-register load decision, FIFO pops, next occupancy, ready and stall.
    always_comb begin
        exc_pending = wb_valid_o & wb_exc_valid_o;
        load        = (~wb_valid_o | wb_ready_i) & grant_found & ~exc_stall_o & ~exc_pending;
        stall_next  = exc_stall_o | exc_pending;
        sel_rec     = head_rec[grant_ch];
        for (int c = 0; c < NUM_CH; c++) begin
            deq[c]        = load & (grant_ch == CW'(c));
            count_next[c] = count[c] + CNTW'(enq[c]) - CNTW'(deq[c]);
            ready_next[c] = (count_next[c] != CNTW'(DEPTH)) & ~stall_next;
        end
`ifdef FU_WB_ARB_AGE_EN
        rr_next = {CW{1'b0}};
`else
        if (!load) begin
            rr_next = rr_ptr;
        end else if (grant_ch == CW'(NUM_CH - 1)) begin
            rr_next = {CW{1'b0}};
        end else begin
            rr_next = grant_ch + CW'(1);
        end
`endif
    end

    // FIFO storage writes; contents need no reset because pointers define validity.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (enq[c]) begin
                mem[c][wr_ptr[c]] <= in_rec[c];
            end
        end
    end

    // Control state, FIFO pointers and the registered writeback port.
    always_ff @(posedge clk) begin
        if (rstn || flush) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr[c] <= {AW{1'b0}};
                rd_ptr[c] <= {AW{1'b0}};
                count[c]  <= {CNTW{1'b0}};
            end
            ch_ready_o     <= {NUM_CH{1'b0}};
            exc_stall_o    <= 1'b0;
            rr_ptr         <= {CW{1'b0}};
            wb_valid_o     <= 1'b0;
            wb_rob_index_o <= {RW{1'b0}};
            wb_rd_we_o     <= 1'b0;
            wb_rd_addr_o   <= {PW{1'b0}};
            wb_data_o      <= {XLEN{1'b0}};
            wb_exc_valid_o <= 1'b0;
            wb_ecause_o    <= {EW{1'b0}};
            wb_ch_o        <= {CW{1'b0}};
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (enq[c]) begin
                    wr_ptr[c] <= wr_ptr[c] + AW'(1);
                end
                if (deq[c]) begin
                    rd_ptr[c] <= rd_ptr[c] + AW'(1);
                end
                count[c] <= count_next[c];
            end
            ch_ready_o  <= ready_next;
            exc_stall_o <= stall_next;
            rr_ptr      <= rr_next;
            if (load) begin
                wb_valid_o     <= 1'b1;
                wb_rob_index_o <= sel_rec.rob;
                wb_rd_we_o     <= sel_rec.we & ~sel_rec.exc;
                wb_rd_addr_o   <= sel_rec.rd;
                wb_data_o      <= sel_rec.data;
                wb_exc_valid_o <= sel_rec.exc;
                wb_ecause_o    <= sel_rec.ecause;
                wb_ch_o        <= grant_ch;
            end else if (wb_ready_i) begin
                wb_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: doc/fu_wb_arb.md
# fu_wb_arb

Parametrised writeback arbiter for the functional-unit cluster. It collects completion records from NUM_CH execution channels (ALU, CMP/branch, LSU, future MUL/DIV), buffers each channel in a small FIFO, and issues one record per cycle to the ROB/PRF through a registered, ready/valid writeback port. It generalises the cluster's sticky exception stall: once an exception record is issued, all channels are back-pressured until flush.

## Interface
- NUM_CH, 3, number of input channels (2..8)
- DEPTH, 2, per-channel FIFO entries (power of two, ≥2)
- XLEN, 64, data width
- ROB_INDEX_WIDTH, 4, ROB index width
- PHY_REG_ADDR_WIDTH, 6, physical register address width
- EXCEPTION_CODE_WIDTH, 4, exception cause width
- clk  in  1  single clock; all state on posedge
- rstn  in  1  synchronous, active-high reset (asserted = 1)
- flush  in  1  synchronous clear; same effect as reset
- ch_valid_i  in  NUM_CH  per-channel record valid
- ch_ready_o  out  NUM_CH  per-channel accept
- ch_rob_index_i  in  NUM_CH*ROB_INDEX_WIDTH  packed; channel c at [c*W +: W]
- ch_rd_we_i  in  NUM_CH  record writes PRF
- ch_rd_addr_i  in  NUM_CH*PHY_REG_ADDR_WIDTH  packed destination
- ch_data_i  in  NUM_CH*XLEN  packed result
- ch_exc_valid_i  in  NUM_CH  record carries exception
- ch_ecause_i  in  NUM_CH*EXCEPTION_CODE_WIDTH  packed cause
- wb_valid_o  out  1  writeback record valid
- wb_ready_i  in  1  ROB/PRF accepts record
- wb_rob_index_o  out  ROB_INDEX_WIDTH
- wb_rd_we_o  out  1  PRF write enable (0 when wb_exc_valid_o)
- wb_rd_addr_o  out  PHY_REG_ADDR_WIDTH
- wb_data_o  out  XLEN
- wb_exc_valid_o  out  1
- wb_ecause_o  out  EXCEPTION_CODE_WIDTH
- wb_ch_o  out  $clog2(NUM_CH)  source channel of current record
- exc_stall_o  out  1  sticky exception stall
- rob_head_i  in  ROB_INDEX_WIDTH  ROB head index (only with FU_WB_ARB_AGE_EN)

## Operation
- Reset/flush (either high at posedge): all FIFOs empty, output register invalid, exc_stall cleared, rr_ptr = 0. Every output 0 during and after reset cycle; ch_ready_o becomes 1 the next cycle. Flush beats a simultaneous enqueue or wb handshake; both are dropped.
- ch_ready_o[c] = ~full[c] & ~exc_stall. Full computed from registered count only; no same-cycle enqueue/dequeue bypass at full.
- Enqueue on ch_valid_i[c] & ch_ready_o[c]; record stored in DEPTH-entry circular FIFO, pointers wrap modulo DEPTH, count width $clog2(DEPTH)+1.
- Output register loads when (~wb_valid_o | wb_ready_i) & any FIFO non-empty & ~exc_stall & ~grant_exc_pending. Granted FIFO pops that cycle.
- Default arbitration: round-robin starting at rr_ptr; after grant to channel g, rr_ptr = (g+1) mod NUM_CH. rr_ptr unchanged with no grant.
- wb_* held stable while wb_valid_o & ~wb_ready_i.
- Exception: when a record with exc_valid is loaded into the output register, exc_stall sets next cycle; no further grants occur (buffered records remain). wb_rd_we_o forced 0 for that record. exc_stall clears only on reset/flush. Exception record itself completes its handshake normally.

## Timing
- Record accepted in cycle 0 reaches wb_valid_o in cycle 2 (FIFO write edge 0, output-register load edge 1), assuming no contention and wb_ready_i high.
- Sustained throughput 1 record/cycle with wb_ready_i held high.
- wb_ready_i low: output stalls, FIFOs fill; ch_ready_o[c] drops the cycle after count[c] reaches DEPTH.
- ch_ready_o all drop the cycle after the exception record is loaded.

## Configuration
- FU_WB_ARB_AGE_EN defined: rob_head_i port exists; arbitration picks the non-empty head with smallest age = (rob_index − rob_head_i) mod 2^ROB_INDEX_WIDTH, ties to lowest channel; rr_ptr unused (held 0).
- Not defined: rob_head_i absent; round-robin as above.

## Test plan
- Reset: rstn=1 two cycles with ch_valid_i=all 1 -> all outputs 0, nothing stored; rstn=0 -> ch_ready_o=all 1 next cycle.
- Single record ch1 rob=5 data=0xABCD rd=12 in cycle 0, wb_ready_i=1 -> wb_valid_o cycle 2 with rob=5, rd=12, we=1, wb_ch_o=1.
- All 3 channels valid every cycle, wb_ready_i=1 -> grants ch0,ch1,ch2,ch0,... (round-robin); with AGE_EN, heads rob 7/3/5 and rob_head_i=2 -> order ch1,ch2,ch0.
- wb_ready_i=0, DEPTH=2, ch0 valid 4 cycles -> 2 entries in FIFO + 1 in output register, ch_ready_o[0]=0; release -> 3 records in order, no loss.
- ch2 exception cause 0x5 then ch0 normal record -> wb_exc_valid_o=1, wb_rd_we_o=0, ecause=5; exc_stall_o=1, ch_ready_o=0, ch0 record never issued; flush -> all cleared, ch_ready_o=all 1 next cycle.
- Flush in same cycle as enqueue and wb handshake -> FIFOs empty, wb_valid_o=0 next cycle.
